clk_meas: RTL and testbench
===========================

CLK_MEAS -- requirements
Module: clk_meas

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 16, the width of the period/high/low counters and outputs.
Ports (name  direction  width  meaning):
REQ-002 The block SHALL have port clock  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port sig_in  input  1  measured signal (e.g. a divided clock); it is asynchronous to clock.
REQ-005 The block SHALL have port clr  input  1  synchronous restart of the measurement, active-high.
REQ-006 The block SHALL have port period  output  WIDTH  clock cycles between the last two qualified sig_in rising edges.
REQ-007 The block SHALL have port high_time  output  WIDTH  clock cycles sig_in was sampled high within that period.
REQ-008 The block SHALL have port low_time  output  WIDTH  period minus high_time.
REQ-009 The block SHALL have port valid  output  1  one-cycle strobe marking a new period/high_time/low_time result.
REQ-010 The block SHALL have port balanced  output  1  |high_time - low_time| <= 1 for the current result.
REQ-011 The block SHALL have port ovf  output  1  sticky flag: the period counter saturated.
REQ-012 The block SHALL have port no_sig  output  1  no rising edge for 2^WIDTH-1 cycles.

Function
REQ-013 sig_in SHALL pass through a 2-flop synchronizer and then one edge-detect register; a rising edge is the sample pair (prev=0, cur=1).
REQ-014 The block SHALL use a two-state FSM: ARM waits for the first rising edge, and MEAS counts between rising edges.
REQ-015 ARM->MEAS SHALL occur on the first rising edge: clear both counters, set period count to 1 and high count to 1, and keep valid at 0.
REQ-016 In MEAS on each non-edge cycle, period count SHALL increment by 1 and high count SHALL increment by 1 when the synchronized sample is 1.
REQ-017 In MEAS on a rising edge, the block SHALL register period = period count, high_time = high count, low_time = period count - high count, and SHALL pulse valid for exactly 1 cycle.
REQ-018 On the same rising edge, the counters SHALL restart at period count 1 and high count 1.
REQ-019 Latency SHALL be: valid asserts 4 clock edges after the clock edge that first samples sig_in high (2 sync + 1 edge register + 1 output register).
REQ-020 balanced SHALL be registered together with the results and SHALL hold until the next valid.
REQ-021 Period counter saturation: at 2^WIDTH-1 the period count SHALL hold, ovf SHALL set, and no_sig SHALL assert; the high count SHALL saturate likewise.
REQ-022 After saturation, the next rising edge SHALL NOT produce valid; the FSM SHALL return to a re-armed MEAS with counters restarted and no_sig cleared, and ovf SHALL stay set.
REQ-023 clr SHALL force ARM, zero both counters, and clear ovf and no_sig.
REQ-024 clr SHALL leave period, high_time, low_time and balanced unchanged.
REQ-025 If clr and a rising edge occur in the same cycle, clr SHALL win and that edge SHALL be ignored.
REQ-026 Between valid strobes, the outputs period, high_time, low_time and balanced SHALL hold their last values.
REQ-027 For a constant sig_in, no valid SHALL ever be produced, and no_sig SHALL assert after 2^WIDTH-1 cycles in MEAS.
REQ-028 In ARM, no_sig SHALL NOT assert.

Reset
REQ-029 Asserting reset SHALL immediately (asynchronously) clear the synchronizer and edge registers, both counters, period, high_time, low_time, valid, balanced, ovf and no_sig, and SHALL set the FSM to ARM.
REQ-030 Reset mid-measurement SHALL discard the partial count.
REQ-031 After reset release, the first rising edge SHALL only arm the FSM; the first valid SHALL come on the second rising edge.

Verification
REQ-032 The bench SHALL cover: sig_in = clock/3 with 50% duty, generated from both clock edges -> period=3 each valid, high_time alternating 1/2, balanced=1.
REQ-033 The bench SHALL cover: sig_in high 3 cycles and low 7 cycles, repeating -> period=10, high_time=3, low_time=7, balanced=0, and the first valid on the 2nd rising edge.
REQ-034 The bench SHALL cover: with WIDTH=4, sig_in stuck at 0 after one rise -> no_sig=1 and ovf=1 after 15 cycles; the next rise gives no valid; the following rise gives a valid with the correct period; ovf stays 1 until clr.
REQ-035 The bench SHALL cover: clr in the same cycle as a rising edge -> no valid, FSM in ARM, ovf=0, and period still equal to its prior value.
REQ-036 The bench SHALL cover: reset asserted mid-period with valid high -> all outputs 0 in the same cycle, and the first valid only after two new rising edges.
REQ-037 The bench SHALL cover: sig_in edge timing relative to the clock -> valid exactly 4 clock edges after the first high sample, with a single-cycle width.

Source files
------------

// File: rtl/clk_meas.sv
// Measures period, high time and low time of an asynchronous signal in core clock cycles.
// Latency: result strobe 4 clock edges after the first edge that samples sig_in high (2 sync, 1 edge, 1 output).
// Backpressure: none; results are strobed with valid and held until the next result.
module clk_meas #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             clr,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic [WIDTH-1:0] low_time,
    output logic             valid,
    output logic             balanced,
    output logic             ovf,
    output logic             no_sig
);

    typedef enum logic {ARM, MEAS} state_t;

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic             sync1, sync2, cur, prev, rise;
    logic [WIDTH-1:0] pcnt, hcnt, pcnt_nxt, hcnt_nxt;
    logic [WIDTH-1:0] period_nxt, high_nxt, low_nxt, low_calc, diff;
    logic             valid_nxt, bal_nxt, ovf_nxt, nosig_nxt, sat_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cur   <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            cur   <= sync2;
            prev  <= cur;
        end
    end

    assign rise     = cur & ~prev;
    assign low_calc = pcnt - hcnt;
    assign diff     = (hcnt >= low_calc) ? (hcnt - low_calc) : (low_calc - hcnt);
    // the period counter is at or about to reach its ceiling this cycle
    assign sat_next = (pcnt >= MAX - ONE);

    always_comb begin
        state_nxt  = state;
        pcnt_nxt   = pcnt;
        hcnt_nxt   = hcnt;
        period_nxt = period;
        high_nxt   = high_time;
        low_nxt    = low_time;
        bal_nxt    = balanced;
        valid_nxt  = 1'b0;
        ovf_nxt    = ovf;
        nosig_nxt  = no_sig;
        if (clr) begin
            state_nxt = ARM;
            pcnt_nxt  = '0;
            hcnt_nxt  = '0;
            ovf_nxt   = 1'b0;
            nosig_nxt = 1'b0;
        end else begin
            case (state)
                ARM: begin
                    if (rise) begin
                        state_nxt = MEAS;
                        pcnt_nxt  = ONE;
                        hcnt_nxt  = ONE;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        pcnt_nxt  = ONE;
                        hcnt_nxt  = ONE;
                        nosig_nxt = 1'b0;
                        // an edge closing a saturated period only re-arms
                        if (!no_sig) begin
                            valid_nxt  = 1'b1;
                            period_nxt = pcnt;
                            high_nxt   = hcnt;
                            low_nxt    = low_calc;
                            bal_nxt    = (diff <= ONE);
                        end
                    end else begin
                        if (pcnt != MAX)
                            pcnt_nxt = pcnt + ONE;
                        if (cur && hcnt != MAX)
                            hcnt_nxt = hcnt + ONE;
                        if (sat_next) begin
                            ovf_nxt   = 1'b1;
                            nosig_nxt = 1'b1;
                        end
                    end
                end
                default: state_nxt = ARM;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ARM;
            pcnt      <= '0;
            hcnt      <= '0;
            period    <= '0;
            high_time <= '0;
            low_time  <= '0;
            valid     <= 1'b0;
            balanced  <= 1'b0;
            ovf       <= 1'b0;
            no_sig    <= 1'b0;
        end else begin
            state     <= state_nxt;
            pcnt      <= pcnt_nxt;
            hcnt      <= hcnt_nxt;
            period    <= period_nxt;
            high_time <= high_nxt;
            low_time  <= low_nxt;
            valid     <= valid_nxt;
            balanced  <= bal_nxt;
            ovf       <= ovf_nxt;
            no_sig    <= nosig_nxt;
        end
    end

endmodule

// File: tb/tb_clk_meas.sv
// Directed bench for clk_meas with a narrow counter so saturation is reachable quickly.
module tb_clk_meas;
    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         sig_in = 1'b0;
    logic         clr = 1'b0;
    logic [W-1:0] period, high_time, low_time;
    logic         valid, balanced, ovf, no_sig;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int hi;
        int lo;
        int per;
        int high;
        int low;
        int bal;
    } vec_t;

    vec_t vecs[7];

    clk_meas #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .sig_in    (sig_in),
        .clr       (clr),
        .period    (period),
        .high_time (high_time),
        .low_time  (low_time),
        .valid     (valid),
        .balanced  (balanced),
        .ovf       (ovf),
        .no_sig    (no_sig)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_high"}, int'(high_time), 0);
        chk({tag, "_low"}, int'(low_time), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_bal"}, int'(balanced), 0);
        chk({tag, "_ovf"}, int'(ovf), 0);
        chk({tag, "_nosig"}, int'(no_sig), 0);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        clr    = 1'b0;
        sig_in = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int p;
        int nv;
        int ec;
        bit exp_v;

        // hi, lo, period, high, low, balanced
        vecs[0] = '{3, 7, 10, 3, 7, 0};
        vecs[1] = '{2, 1, 3, 2, 1, 1};
        vecs[2] = '{1, 2, 3, 1, 2, 1};
        vecs[3] = '{5, 5, 10, 5, 5, 1};
        vecs[4] = '{4, 6, 10, 4, 6, 0};
        vecs[5] = '{7, 6, 13, 7, 6, 1};
        vecs[6] = '{1, 1, 2, 1, 1, 1};

        repeat (2) @(negedge clock);
        chk_zero("reset_state");
        reset = 1'b0;

        // steady patterns: rise #1 only arms, valid 4 samples after rise #2, then every period
        foreach (vecs[v]) begin
            do_reset();
            p = vecs[v].hi + vecs[v].lo;
            for (int i = 0; i < 3 * p + 6; i++) begin
                @(negedge clock);
                exp_v = (i >= p + 4) && ((i - 4) % p == 0);
                chk($sformatf("vec%0d_valid_c%0d", v, i), int'(valid), int'(exp_v));
                if (exp_v) begin
                    chk($sformatf("vec%0d_period", v), int'(period), vecs[v].per);
                    chk($sformatf("vec%0d_high", v), int'(high_time), vecs[v].high);
                    chk($sformatf("vec%0d_low", v), int'(low_time), vecs[v].low);
                    chk($sformatf("vec%0d_bal", v), int'(balanced), vecs[v].bal);
                    chk($sformatf("vec%0d_ovf", v), int'(ovf), 0);
                end
                sig_in = ((i % p) < vecs[v].hi);
            end
        end

        // clock/3 at 50% duty, toggled 1 unit after every third clock edge of either polarity
        do_reset();
        nv = 0;
        ec = 0;
        fork
            begin
                repeat (64) begin
                    @(clock);
                    ec++;
                    if (ec % 3 == 0) begin
                        #1;
                        sig_in = ~sig_in;
                    end
                end
            end
            begin
                repeat (31) begin
                    @(negedge clock);
                    if (valid) begin
                        nv++;
                        chk("div3_period", int'(period), 3);
                        chk("div3_high_range", int'(high_time == 1 || high_time == 2), 1);
                        chk("div3_low", int'(low_time), 3 - int'(high_time));
                        chk("div3_bal", int'(balanced), 1);
                    end
                end
            end
        join
        chk("div3_valid_count", int'(nv >= 5), 1);

        // constant input: no_sig stays low while armed, then saturates with no valid
        do_reset();
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            chk("const0_valid", int'(valid), 0);
        end
        chk("arm_no_sig", int'(no_sig), 0);
        sig_in = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            chk("const1_valid", int'(valid), 0);
            if (i == 16) chk("const1_nosig_before", int'(no_sig), 0);
            if (i == 17) chk("const1_nosig_after", int'(no_sig), 1);
        end
        chk("const1_ovf", int'(ovf), 1);

        // saturation, re-arm, recovery, then clr colliding with a rising edge
        do_reset();
        for (int i = 0; i < 72; i++) begin
            @(negedge clock);
            exp_v = (i == 39) || (i == 69);
            chk($sformatf("sat_valid_c%0d", i), int'(valid), int'(exp_v));
            if (i == 17) chk("sat_nosig_pre", int'(no_sig), 0);
            if (i == 18) begin
                chk("sat_nosig_set", int'(no_sig), 1);
                chk("sat_ovf_set", int'(ovf), 1);
            end
            if (i == 28) chk("sat_nosig_hold", int'(no_sig), 1);
            if (i == 29) begin
                chk("sat_nosig_clear", int'(no_sig), 0);
                chk("sat_ovf_sticky", int'(ovf), 1);
            end
            if (i == 39) begin
                chk("sat_period", int'(period), 10);
                chk("sat_high", int'(high_time), 2);
                chk("sat_low", int'(low_time), 8);
                chk("sat_bal", int'(balanced), 0);
                chk("sat_ovf_after_valid", int'(ovf), 1);
            end
            if (i == 47) chk("sat_ovf_before_clr", int'(ovf), 1);
            if (i == 49) begin
                chk("clr_ovf", int'(ovf), 0);
                chk("clr_nosig", int'(no_sig), 0);
                chk("clr_period_kept", int'(period), 10);
                chk("clr_high_kept", int'(high_time), 2);
            end
            if (i == 69) begin
                chk("rearm_period", int'(period), 10);
                chk("rearm_high", int'(high_time), 2);
            end
            sig_in = (i == 0) || (i == 1) || (i == 25) || (i == 26) ||
                     (i >= 35 && ((i - 35) % 10) < 2);
            clr = (i == 48);
        end
        clr = 1'b0;

        // asynchronous reset while valid is high
        do_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (i == 15) reset = 1'b0;
            exp_v = (i == 14) || (i == 34);
            chk($sformatf("rst_valid_c%0d", i), int'(valid), int'(exp_v));
            if (i == 14) begin
                reset = 1'b1;
                #1;
                chk_zero("rst_mid");
            end
            if (i == 34) begin
                chk("rst_period", int'(period), 10);
                chk("rst_high", int'(high_time), 3);
                chk("rst_low", int'(low_time), 7);
            end
            sig_in = ((i % 10) < 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
